// File: rtl/rv32_pkg.sv
// Shared decode types for the RV32I(+M) decode stage: opcode map, ALU codes,
// write-back / branch enums and the decoded payload carried through the FIFO.
package rv32_pkg;

  localparam logic [4:0] OPC_LOAD     = 5'b00000;
  localparam logic [4:0] OPC_MISC_MEM = 5'b00011;
  localparam logic [4:0] OPC_OP_IMM   = 5'b00100;
  localparam logic [4:0] OPC_AUIPC    = 5'b00101;
  localparam logic [4:0] OPC_STORE    = 5'b01000;
  localparam logic [4:0] OPC_OP       = 5'b01100;
  localparam logic [4:0] OPC_LUI      = 5'b01101;
  localparam logic [4:0] OPC_BRANCH   = 5'b11000;
  localparam logic [4:0] OPC_JALR     = 5'b11001;
  localparam logic [4:0] OPC_JAL      = 5'b11011;
  localparam logic [4:0] OPC_SYSTEM   = 5'b11100;

  // alu_func = {m_ext, b30, funct3}
  localparam logic [4:0] ALU_OP_ADD = 5'b0_0000;
  localparam logic [4:0] ALU_OP_SUB = 5'b0_1000;
  localparam logic [4:0] ALU_OP_SRA = 5'b0_1101;
  localparam logic [4:0] ALU_OP_MUL = 5'b1_0000;

  typedef enum logic [1:0] {
    WB_ALU = 2'd0,
    WB_PC4 = 2'd1,
    WB_LSU = 2'd2
  } wb_source_t;

  typedef enum logic [2:0] {
    BR_NOP = 3'd0,
    BR_EQ  = 3'd1,
    BR_NE  = 3'd2,
    BR_GE  = 3'd4,
    BR_LT  = 3'd5
  } br_condition_t;

  typedef struct packed {
    logic [4:0]    rd;
    logic [4:0]    rs1;
    logic [4:0]    rs2;
    logic [31:0]   imm;
    logic [4:0]    alu_func;
    logic          op0_use_pc;
    logic          op0_zero;
    logic          op1_use_imm;
    logic          rf_we;
    logic [3:0]    ram_req;
    logic          ram_wr;
    wb_source_t    wb_source;
    br_condition_t br_cond;
    logic          br_unsigned;
    logic          br_is_cond;
    logic          br_jmp;
    logic          illegal;
  } rv32_dec_t;

endpackage

// File: rtl/rv32_mod_decode_comb.sv
// Combinational opcode-driven RV32I(+M) decoder: raw instruction -> rv32_dec_t.
// Illegal encodings collapse to an all-zero payload with only the illegal flag set.
module rv32_mod_decode_comb
  import rv32_pkg::*;
#(
  parameter bit HAS_M = 1'b1,
  parameter int PC_W  = 32
) (
  input  logic [31:0]     i_instr,
  input  logic [PC_W-1:0] i_pc,
  output rv32_dec_t       o_dec,
  output logic [PC_W-1:0] o_pc
);

  logic [4:0]  w_opc;
  logic [2:0]  w_f3;
  logic [6:0]  w_f7;
  logic [31:0] w_imm_i, w_imm_s, w_imm_b, w_imm_u, w_imm_j;
  rv32_dec_t   w_dec;
  logic        w_ill;

  assign w_opc   = i_instr[6:2];
  assign w_f3    = i_instr[14:12];
  assign w_f7    = i_instr[31:25];
  assign w_imm_i = {{20{i_instr[31]}}, i_instr[31:20]};
  assign w_imm_s = {{20{i_instr[31]}}, i_instr[31:25], i_instr[11:7]};
  assign w_imm_b = {{19{i_instr[31]}}, i_instr[31], i_instr[7], i_instr[30:25], i_instr[11:8], 1'b0};
  assign w_imm_u = {i_instr[31:12], 12'b0};
  assign w_imm_j = {{11{i_instr[31]}}, i_instr[31], i_instr[19:12], i_instr[20], i_instr[30:21], 1'b0};

  always_comb begin
    w_dec = '0;
    w_ill = 1'b0;
    if (i_instr[1:0] != 2'b11) begin
      w_ill = 1'b1;
    end else begin
      case (w_opc)
        OPC_OP: begin
          w_dec.rd    = i_instr[11:7];
          w_dec.rs1   = i_instr[19:15];
          w_dec.rs2   = i_instr[24:20];
          w_dec.rf_we = 1'b1;
          if (w_f7 == 7'b000_0000 || w_f7 == 7'b010_0000) w_dec.alu_func = {1'b0, i_instr[30], w_f3};
          else if (w_f7 == 7'b000_0001 && HAS_M)           w_dec.alu_func = {2'b10, w_f3};
          else                                              w_ill = 1'b1;
        end
        OPC_OP_IMM: begin
          w_dec.rd          = i_instr[11:7];
          w_dec.rs1         = i_instr[19:15];
          w_dec.imm         = w_imm_i;
          w_dec.op1_use_imm = 1'b1;
          w_dec.rf_we       = 1'b1;
          // b30 only distinguishes SRAI from SRLI; elsewhere it is immediate data
          w_dec.alu_func    = {1'b0, i_instr[30] && (w_f3 == 3'b101), w_f3};
        end
        OPC_LOAD: begin
          w_dec.rd          = i_instr[11:7];
          w_dec.rs1         = i_instr[19:15];
          w_dec.imm         = w_imm_i;
          w_dec.op1_use_imm = 1'b1;
          w_dec.rf_we       = 1'b1;
          w_dec.ram_req     = {1'b1, w_f3};
          w_dec.wb_source   = WB_LSU;
          if (w_f3 == 3'b011 || w_f3 == 3'b110 || w_f3 == 3'b111) w_ill = 1'b1;
        end
        OPC_STORE: begin
          w_dec.rs1         = i_instr[19:15];
          w_dec.rs2         = i_instr[24:20];
          w_dec.imm         = w_imm_s;
          w_dec.op1_use_imm = 1'b1;
          w_dec.ram_req     = {1'b1, w_f3};
          w_dec.ram_wr      = 1'b1;
          if (w_f3 > 3'b010) w_ill = 1'b1;
        end
        OPC_BRANCH: begin
          w_dec.rs1         = i_instr[19:15];
          w_dec.rs2         = i_instr[24:20];
          w_dec.imm         = w_imm_b;
          w_dec.op0_use_pc  = 1'b1;
          w_dec.op1_use_imm = 1'b1;
          w_dec.br_is_cond  = 1'b1;
          w_dec.br_unsigned = w_f3[2] & w_f3[1];
          case (w_f3)
            3'b000:         w_dec.br_cond = BR_EQ;
            3'b001:         w_dec.br_cond = BR_NE;
            3'b100, 3'b110: w_dec.br_cond = BR_LT;
            3'b101, 3'b111: w_dec.br_cond = BR_GE;
            default:        w_ill = 1'b1;
          endcase
        end
        OPC_JAL: begin
          w_dec.rd          = i_instr[11:7];
          w_dec.imm         = w_imm_j;
          w_dec.op0_use_pc  = 1'b1;
          w_dec.op1_use_imm = 1'b1;
          w_dec.rf_we       = 1'b1;
          w_dec.wb_source   = WB_PC4;
          w_dec.br_jmp      = 1'b1;
        end
        OPC_JALR: begin
          w_dec.rd          = i_instr[11:7];
          w_dec.rs1         = i_instr[19:15];
          w_dec.imm         = w_imm_i;
          w_dec.op1_use_imm = 1'b1;
          w_dec.rf_we       = 1'b1;
          w_dec.wb_source   = WB_PC4;
          w_dec.br_jmp      = 1'b1;
          if (w_f3 != 3'b000) w_ill = 1'b1;
        end
        OPC_LUI, OPC_AUIPC: begin
          w_dec.rd          = i_instr[11:7];
          w_dec.imm         = w_imm_u;
          w_dec.op0_zero    = (w_opc == OPC_LUI);
          w_dec.op0_use_pc  = (w_opc == OPC_AUIPC);
          w_dec.op1_use_imm = 1'b1;
          w_dec.rf_we       = 1'b1;
        end
        OPC_MISC_MEM, OPC_SYSTEM: begin
          // fences and system calls retire as side-effect-free NOPs
        end
        default: w_ill = 1'b1;
      endcase
    end
    if (w_dec.rd == 5'd0) w_dec.rf_we = 1'b0;
    if (w_ill) begin
      w_dec         = '0;
      w_dec.illegal = 1'b1;
    end
  end

  assign o_dec = w_dec;
  assign o_pc  = i_pc;

endmodule

// File: rtl/rv32_mod_decode_stage.sv
// Registered decode stage: decodes the fetched instruction and buffers the result
// in a DEPTH-entry FIFO; no combinational path from the fetch side to the execute side.
module rv32_mod_decode_stage
  import rv32_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter bit HAS_M = 1'b1,
  parameter int PC_W  = 32
) (
  input  logic            clk,
  input  logic            rstn,
  input  logic            flush_i,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_instr,
  input  logic [PC_W-1:0] in_pc,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [PC_W-1:0] out_pc,
  output logic [4:0]      out_rd,
  output logic [4:0]      out_rs1,
  output logic [4:0]      out_rs2,
  output logic [31:0]     out_imm,
  output logic [4:0]      out_alu_func,
  output logic            out_alu_op0_use_pc,
  output logic            out_alu_op0_zero,
  output logic            out_alu_op1_use_imm,
  output logic            out_rf_write0_enable,
  output logic [3:0]      out_ram_req,
  output logic            out_ram_wr,
  output logic [1:0]      out_wb_source,
  output logic [2:0]      out_br_cond,
  output logic            out_br_unsigned,
  output logic            out_br_is_cond,
  output logic            out_br_jmp,
  output logic            out_illegal
);

  localparam int              PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int              CNT_W = $clog2(DEPTH + 1);
  localparam logic [PTR_W-1:0] LAST  = PTR_W'(DEPTH - 1);
  localparam logic [CNT_W-1:0] FULL  = CNT_W'(DEPTH);

  rv32_dec_t        w_dec, w_head;
  logic [PC_W-1:0]  w_pc, w_head_pc;
  logic             w_push, w_pop;

  rv32_dec_t        r_mem    [DEPTH];
  logic [PC_W-1:0]  r_pc_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr, r_rd_ptr;
  logic [CNT_W-1:0] r_count;

  rv32_mod_decode_comb #(.HAS_M(HAS_M), .PC_W(PC_W)) u_decode (
    .i_instr (in_instr),
    .i_pc    (in_pc),
    .o_dec   (w_dec),
    .o_pc    (w_pc)
  );

  // Handshake: a beat transfers on an edge where valid && ready; valid never
  // depends on ready, and the head payload is held until it is accepted.
  // Flush blocks both transfers in its cycle.
  assign in_ready  = (r_count != FULL) && !flush_i;
  assign out_valid = (r_count != '0);
  assign w_push    = in_valid && in_ready;
  assign w_pop     = out_valid && out_ready && !flush_i;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (flush_i) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= (r_wr_ptr == LAST) ? '0 : r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= (r_rd_ptr == LAST) ? '0 : r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr]    <= w_dec;
      r_pc_mem[r_wr_ptr] <= w_pc;
    end
  end

  // Storage is not reset; masking with out_valid keeps the payload zero when empty.
  assign w_head    = out_valid ? r_mem[r_rd_ptr]    : '0;
  assign w_head_pc = out_valid ? r_pc_mem[r_rd_ptr] : '0;

  assign out_pc               = w_head_pc;
  assign out_rd               = w_head.rd;
  assign out_rs1              = w_head.rs1;
  assign out_rs2              = w_head.rs2;
  assign out_imm              = w_head.imm;
  assign out_alu_func         = w_head.alu_func;
  assign out_alu_op0_use_pc   = w_head.op0_use_pc;
  assign out_alu_op0_zero     = w_head.op0_zero;
  assign out_alu_op1_use_imm  = w_head.op1_use_imm;
  assign out_rf_write0_enable = w_head.rf_we;
  assign out_ram_req          = w_head.ram_req;
  assign out_ram_wr           = w_head.ram_wr;
  assign out_wb_source        = w_head.wb_source;
  assign out_br_cond          = w_head.br_cond;
  assign out_br_unsigned      = w_head.br_unsigned;
  assign out_br_is_cond       = w_head.br_is_cond;
  assign out_br_jmp           = w_head.br_jmp;
  assign out_illegal          = w_head.illegal;

endmodule
